// File: rtl/slow_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : slow_clk_monitor
// Purpose  : Samples a slow divided clock in the fast clk domain, emits
//            one-cycle rise/fall ticks, measures the half-period in clk
//            cycles and flags a stalled divider after TIMEOUT idle cycles.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous active-high reset
//            slow_in      - divided clock, asynchronous to clk
//            tick_rise    - one-cycle pulse per synchronized rising edge
//            tick_fall    - one-cycle pulse per synchronized falling edge
//            half_period  - clk cycles between the last two edges
//            period_valid - half_period holds a trusted measurement
//            stalled      - no edge seen for TIMEOUT cycles
// Revision : 1.0 - initial release
// ============================================================================
module slow_clk_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 27,
    parameter int TIMEOUT     = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_in,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             stalled
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_LOCKED  = 2'd2,
        S_STALLED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_half_period;
    logic                   r_tick_rise;
    logic                   r_tick_fall;
    logic                   r_period_valid;
    logic                   r_stalled;
    state_t                 r_state;

    logic                   w_sync;
    logic                   w_edge;
    logic                   w_timeout;

    // Synchronizer chain: bit 0 takes the raw input, the MSB is the
    // metastability-safe value used by everything downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], slow_in};
        end
    end

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_edge    = w_sync ^ r_prev;
    // An edge in the same cycle overrides the timeout.
    assign w_timeout = (r_cnt == c_timeout) && !w_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev         <= 1'b0;
            r_cnt          <= '0;
            r_half_period  <= '0;
            r_tick_rise    <= 1'b0;
            r_tick_fall    <= 1'b0;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b0;
            r_state        <= S_IDLE;
        end else begin
            r_prev      <= w_sync;
            r_tick_rise <= w_edge & w_sync;
            r_tick_fall <= w_edge & ~w_sync;

            // Interval counter saturates instead of wrapping so a very long
            // stall can never alias to a short-looking interval.
            if (w_edge) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + c_cnt_one;
            end

            if (w_edge) begin
                case (r_state)
                    S_IDLE: begin
                        r_state        <= S_ARMED;
                        r_period_valid <= 1'b0;
                        r_stalled      <= 1'b0;
                    end
                    S_ARMED, S_LOCKED: begin
                        // cnt counts cycles since the previous edge cycle, so
                        // the interval between detections is cnt + 1.
                        r_half_period  <= r_cnt + c_cnt_one;
                        r_state        <= S_LOCKED;
                        r_period_valid <= 1'b1;
                        r_stalled      <= 1'b0;
                    end
                    default: begin
                        // Leaving a stall: the gap just ended is not a real
                        // half-period, so this edge only re-arms.
                        r_state        <= S_ARMED;
                        r_period_valid <= 1'b0;
                        r_stalled      <= 1'b0;
                    end
                endcase
            end else if (w_timeout) begin
                r_state        <= S_STALLED;
                r_period_valid <= 1'b0;
                r_stalled      <= 1'b1;
            end
        end
    end

    assign tick_rise    = r_tick_rise;
    assign tick_fall    = r_tick_fall;
    assign half_period  = r_half_period;
    assign period_valid = r_period_valid;
    assign stalled      = r_stalled;

endmodule
`default_nettype wire

// File: tb/tb_slow_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_slow_clk_monitor
// Purpose  : Directed and randomized stimulus for slow_clk_monitor, checked
//            every cycle against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slow_clk_monitor;

    localparam int SYNC = 2;
    localparam int CW   = 16;
    localparam int TO   = 20;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          slow_in = 1'b0;
    logic          tick_rise;
    logic          tick_fall;
    logic [CW-1:0] half_period;
    logic          period_valid;
    logic          stalled;

    slow_clk_monitor #(
        .SYNC_STAGES (SYNC),
        .CNT_W       (CW),
        .TIMEOUT     (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .slow_in      (slow_in),
        .tick_rise    (tick_rise),
        .tick_fall    (tick_fall),
        .half_period  (half_period),
        .period_valid (period_valid),
        .stalled      (stalled)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: history of raw samples (newest first), cycles since
    // the last detected edge, number of edges since reset/stall, stall flag.
    bit samp[$];
    int age;
    int edges;
    bit stl;
    bit e_rise;
    bit e_fall;
    int e_hp;

    function automatic void mdl_reset();
        samp.delete();
        for (int i = 0; i < SYNC + 1; i++) samp.push_back(1'b0);
        age    = 0;
        edges  = 0;
        stl    = 1'b0;
        e_rise = 1'b0;
        e_fall = 1'b0;
        e_hp   = 0;
    endfunction

    function automatic void mdl_clock(bit v);
        bit ev;
        samp.push_front(v);
        // The value seen SYNC clocks late is compared with the one before it.
        ev     = (samp[SYNC] != samp[SYNC+1]);
        e_rise = ev && samp[SYNC];
        e_fall = ev && !samp[SYNC];
        void'(samp.pop_back());
        if (ev) begin
            if (stl) begin
                stl   = 1'b0;
                edges = 1;
            end else begin
                if (edges >= 1) e_hp = age + 1;
                if (edges < 2) edges++;
            end
            age = 0;
        end else begin
            if (age == TO) begin
                stl   = 1'b1;
                edges = 0;
            end
            if (age < CMAX) age++;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit v);
        slow_in = v;
        @(posedge clk);
        if (rst) mdl_reset();
        else     mdl_clock(v);
        #1;
        chk("tick_rise",    32'(tick_rise),    32'(e_rise));
        chk("tick_fall",    32'(tick_fall),    32'(e_fall));
        chk("half_period",  32'(half_period),  32'(e_hp));
        chk("period_valid", 32'(period_valid), 32'(!stl && edges >= 2));
        chk("stalled",      32'(stalled),      32'(stl));
        chk("ticks_excl",   32'(tick_rise & tick_fall), 32'd0);
    endtask

    task automatic run(input bit v, input int n);
        for (int i = 0; i < n; i++) cyc(v);
    endtask

    task automatic do_reset(input bit v);
        slow_in = v;
        rst = 1'b1;
        #1;
        chk("async_rst_rise",  32'(tick_rise),    32'd0);
        chk("async_rst_fall",  32'(tick_fall),    32'd0);
        chk("async_rst_hp",    32'(half_period),  32'd0);
        chk("async_rst_valid", 32'(period_valid), 32'd0);
        chk("async_rst_stall", 32'(stalled),      32'd0);
        mdl_reset();
        run(v, 2);
        rst = 1'b0;
    endtask

    initial begin
        bit lvl;
        int p;
        mdl_reset();
        #2;

        // Idle after reset: stall follows cnt reaching TIMEOUT.
        do_reset(1'b0);
        run(1'b0, TO);
        chk("no_stall_early", 32'(stalled), 32'd0);
        cyc(1'b0);
        chk("stall_on_timeout", 32'(stalled), 32'd1);
        chk("stall_not_valid",  32'(period_valid), 32'd0);
        run(1'b0, 5);

        // Toggle every 8 cycles: first tick three cycles after the toggle.
        do_reset(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        chk("no_rise_early", 32'(tick_rise), 32'd0);
        cyc(1'b1);
        chk("first_rise_lat", 32'(tick_rise), 32'd1);
        chk("first_rise_hp",  32'(half_period), 32'd0);
        run(1'b1, 5);
        lvl = 1'b1;
        for (int k = 0; k < 6; k++) begin
            lvl = ~lvl;
            run(lvl, 8);
        end
        chk("locked_hp8",    32'(half_period),  32'd8);
        chk("locked_valid8", 32'(period_valid), 32'd1);

        // Period drops from 8 to 5.
        lvl = ~lvl;
        run(lvl, 5);
        lvl = ~lvl;
        run(lvl, 3);
        chk("hp_after_change", 32'(half_period),  32'd5);
        chk("valid_no_drop",   32'(period_valid), 32'd1);
        run(lvl, 2);

        // Random half-periods, all below the timeout.
        for (int k = 0; k < 12; k++) begin
            p = int'($urandom_range(1, TO - 1));
            lvl = ~lvl;
            run(lvl, p);
        end
        lvl = ~lvl;
        run(lvl, 8);
        lvl = ~lvl;
        run(lvl, 8);

        // Stall from LOCKED, then recovery.
        lvl = ~lvl;
        run(lvl, TO + 3);
        chk("no_stall_before", 32'(stalled), 32'd0);
        cyc(lvl);
        chk("stall_from_lock", 32'(stalled),      32'd1);
        chk("stall_drops_val", 32'(period_valid), 32'd0);
        run(lvl, 4);
        lvl = ~lvl;
        run(lvl, 3);
        chk("rearm_tick",    32'(tick_rise | tick_fall), 32'd1);
        chk("rearm_unstall", 32'(stalled),      32'd0);
        chk("rearm_invalid", 32'(period_valid), 32'd0);
        run(lvl, 5);
        lvl = ~lvl;
        run(lvl, 3);
        chk("relock_valid", 32'(period_valid), 32'd1);
        chk("relock_hp",    32'(half_period),  32'd8);
        run(lvl, 5);

        // Edge lands on the cycle cnt == TIMEOUT: edge wins.
        lvl = ~lvl;
        run(lvl, TO + 1);
        lvl = ~lvl;
        run(lvl, 3);
        chk("edge_at_timeout_hp",    32'(half_period),  32'd21);
        chk("edge_at_timeout_valid", 32'(period_valid), 32'd1);
        chk("edge_at_timeout_stall", 32'(stalled),      32'd0);
        run(lvl, 5);

        // Reset while LOCKED with slow_in high.
        lvl = ~lvl;
        run(lvl, 8);
        lvl = ~lvl;
        run(lvl, 8);
        if (lvl == 1'b0) begin
            lvl = 1'b1;
            run(lvl, 8);
        end
        do_reset(1'b1);
        run(1'b1, 3);
        chk("post_rst_rise",  32'(tick_rise),    32'd1);
        chk("post_rst_hp",    32'(half_period),  32'd0);
        chk("post_rst_valid", 32'(period_valid), 32'd0);
        run(1'b1, 5);
        run(1'b0, 8);
        run(1'b1, 8);
        chk("post_rst_lock_hp",    32'(half_period),  32'd8);
        chk("post_rst_lock_valid", 32'(period_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
